instruction_fetch_unit: RTL

- IF stage of the MIPS32 pipeline.
- Owns the PC and drives Address to the combinational instruction memory.
- Captures the returned Instruction into the IF/ID pipeline register.
- Applies branch/jump redirects, stalls, flushes and halt from downstream ID/control logic, and counts valid fetches.

---
 rtl/instruction_fetch_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Instruction fetch stage for a MIPS32 pipeline. The unit owns the PC and
// drives it to a combinational instruction memory. It captures the returned
// word into the IF/ID pipeline register. It also applies redirects, stalls,
// flushes and halt requests from downstream, and counts valid fetches.
//
// Ports
//   Clk              : clock; all state updates on the rising edge
//   Rst_n            : asynchronous active-low reset
//   Stall            : hold PC and the IF/ID register
//   Flush            : bubble IF/ID on this edge
//   BranchTaken      : branch resolved taken in ID
//   BranchTarget     : branch destination (low two bits forced to 00)
//   Jump             : J-type jump decoded in ID
//   JumpIndex        : 26-bit instr_index of the jump
//   Halt             : stop fetching until reset
//   Instruction      : memory word for the current Address
//   Address          : current PC, straight from the PC register
//   IfId_Instruction : registered instruction to ID
//   IfId_PCPlus4     : registered PC+4 of that instruction
//   IfId_Valid       : IF/ID holds a real instruction
//   Halted           : FSM is in HALTED (doubles as the state debug view)
//   MisalignErr      : sticky, set when a taken branch target was unaligned
//   FetchCount       : number of instructions latched with IfId_Valid = 1
//
// Handshake: this stage has no ready/valid back-pressure of its own.
// IfId_Valid qualifies the IF/ID payload on every cycle. Stall is the only
// hold request, and it is honoured on the same edge it is sampled.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Stall,
   input  logic                 Flush,
   input  logic                 BranchTaken,
   input  logic [31:0]          BranchTarget,
   input  logic                 Jump,
   input  logic [25:0]          JumpIndex,
   input  logic                 Halt,
   input  logic [31:0]          Instruction,
   output logic [31:0]          Address,
   output logic [31:0]          IfId_Instruction,
   output logic [31:0]          IfId_PCPlus4,
   output logic                 IfId_Valid,
   output logic                 Halted,
   output logic                 MisalignErr,
   output logic [CNT_WIDTH-1:0] FetchCount
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [31:0]            ifid_instr_q, ifid_instr_d;
   logic [31:0]            ifid_pcp4_q, ifid_pcp4_d;
   logic                   ifid_valid_q, ifid_valid_d;
   logic                   misalign_q, misalign_d;
   logic [CNT_WIDTH-1:0]   fetch_cnt_q, fetch_cnt_d;
   logic [31:0]            pc_plus4;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   assign pc_plus4 = pc_q + 32'd4;

   // Next-state logic. Priority in RUN, highest first:
   // Halt, BranchTaken, Jump, Stall, then normal fetch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pcp4_d  = ifid_pcp4_q;
      ifid_valid_d = ifid_valid_q;
      misalign_d   = misalign_q;
      fetch_cnt_d  = fetch_cnt_q;

      if (state_q == ST_RUN) begin
         if (Halt) begin
            state_d      = ST_HALTED;
            ifid_valid_d = 1'b0;
         end else if (BranchTaken) begin
            // An unaligned target is still followed, rounded down to a word.
            pc_d         = {BranchTarget[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            if (BranchTarget[1:0] != 2'b00) begin
               misalign_d = 1'b1;
            end
         end else if (Jump) begin
            // The region bits come from the jump's own PC+4, which sits in IF/ID.
            pc_d         = {ifid_pcp4_q[31:28], JumpIndex, 2'b00};
            ifid_valid_d = 1'b0;
         end else if (Stall) begin
            if (Flush) begin
               ifid_valid_d = 1'b0;
            end
         end else begin
            pc_d         = pc_plus4;
            ifid_instr_d = Instruction;
            ifid_pcp4_d  = pc_plus4;
            ifid_valid_d = !Flush;
            if (!Flush) begin
               fetch_cnt_d = fetch_cnt_q + CNT_ONE;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q      <= ST_RUN;
         pc_q         <= RESET_PC;
         ifid_instr_q <= 32'd0;
         ifid_pcp4_q  <= 32'd0;
         ifid_valid_q <= 1'b0;
         misalign_q   <= 1'b0;
         fetch_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pcp4_q  <= ifid_pcp4_d;
         ifid_valid_q <= ifid_valid_d;
         misalign_q   <= misalign_d;
         fetch_cnt_q  <= fetch_cnt_d;
      end
   end

   assign Address          = pc_q;
   assign IfId_Instruction = ifid_instr_q;
   assign IfId_PCPlus4     = ifid_pcp4_q;
   assign IfId_Valid       = ifid_valid_q;
   assign Halted           = (state_q == ST_HALTED);
   assign MisalignErr      = misalign_q;
   assign FetchCount       = fetch_cnt_q;

endmodule
